// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the pipeline boundary registers: bubble constants,
// occupancy type and per-boundary bundle widths.
package pipe_stage_skid_pkg;

  typedef logic [1:0] occ_t;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  localparam int FD_WIDTH = 72;
  localparam int DE_WIDTH = 72;
  localparam int EM_WIDTH = 72;
  localparam int MW_WIDTH = 72;

  localparam int CTRL_WIDTH = FD_WIDTH - 64;

  // F/D bundle: instruction word in the low bits so a zero control field plus
  // an RV32 NOP forms a harmless bubble.
  typedef struct packed {
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [31:0]           pc;
    logic [31:0]           instr;
  } fd_bundle_t;

  localparam fd_bundle_t FD_BUBBLE = '{ctrl: '0, pc: '0, instr: RV32_NOP};

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready/data handshake between adjacent pipeline stages.
interface pipe_stage_skid_if #(
  parameter int WIDTH = 72
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline boundary register with a 2-entry skid buffer so up.ready is a flop,
// synchronous flush and bubble substitution while empty.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int               WIDTH        = 72,
  parameter logic [WIDTH-1:0] BUBBLE_VAL   = '0,
  parameter bit               BUBBLE_ON_IV = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  pipe_stage_skid_if.slave   up,
  pipe_stage_skid_if.master  dn,
  output occ_t               occupancy
);

  logic             valid_m;
  logic             valid_s;
  logic             in_ready_q;
  logic [WIDTH-1:0] data_m;
  logic [WIDTH-1:0] data_s;

  logic in_fire;
  logic out_fire;
  logic valid_m_nxt;
  logic valid_s_nxt;
  logic load_m_in;
  logic load_m_s;
  logic load_s;

  assign in_fire  = up.valid & in_ready_q;
  assign out_fire = valid_m & dn.ready;

  always_comb begin
    valid_m_nxt = valid_m;
    valid_s_nxt = valid_s;
    load_m_in   = 1'b0;
    load_m_s    = 1'b0;
    load_s      = 1'b0;
    if (!valid_m) begin
      if (in_fire) begin
        valid_m_nxt = 1'b1;
        load_m_in   = 1'b1;
      end
    end else if (out_fire) begin
      if (valid_s) begin
        load_m_s    = 1'b1;
        valid_s_nxt = 1'b0;
      end else if (in_fire) begin
        load_m_in   = 1'b1;
      end else begin
        valid_m_nxt = 1'b0;
      end
    end else if (in_fire) begin
      // downstream stalled: park the new bundle behind M
      valid_s_nxt = 1'b1;
      load_s      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_m    <= 1'b0;
      valid_s    <= 1'b0;
      data_m     <= BUBBLE_VAL;
      data_s     <= BUBBLE_VAL;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      valid_m    <= 1'b0;
      valid_s    <= 1'b0;
      data_m     <= BUBBLE_VAL;
      data_s     <= BUBBLE_VAL;
      in_ready_q <= 1'b1;
    end else begin
      valid_m    <= valid_m_nxt;
      valid_s    <= valid_s_nxt;
      in_ready_q <= ~valid_s_nxt;
      if (load_m_in) begin
        data_m <= up.data;
      end else if (load_m_s) begin
        data_m <= data_s;
      end
      if (load_s) begin
        data_s <= up.data;
      end
    end
  end

  assign up.ready  = in_ready_q;
  assign dn.valid  = valid_m;
  assign dn.data   = (BUBBLE_ON_IV && !valid_m) ? BUBBLE_VAL : data_m;
  assign occupancy = {1'b0, valid_m} + {1'b0, valid_s};

  a_no_fire_when_skid_full: assert property (@(posedge clk) disable iff (!rst)
    !(in_fire && valid_s));

  a_hold_on_stall: assert property (@(posedge clk) disable iff (!rst)
    (dn.valid && !dn.ready && !flush) |=> $stable(dn.data));

  a_skid_implies_main: assert property (@(posedge clk) disable iff (!rst)
    !(valid_s && !valid_m));

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus a random
// valid/ready/flush run, all compared against a queue-based reference model.
module tb_pipe_stage_skid;
  import pipe_stage_skid_pkg::*;

  localparam int            W   = 72;
  localparam logic [W-1:0]  BUB = 72'hA5_0000_0000_0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  occ_t occupancy;

  pipe_stage_skid_if #(.WIDTH(W)) up ();
  pipe_stage_skid_if #(.WIDTH(W)) dn ();

  pipe_stage_skid #(
    .WIDTH        (W),
    .BUBBLE_VAL   (BUB),
    .BUBBLE_ON_IV (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .up        (up),
    .dn        (dn),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Reference: the stage behaves as a FIFO of depth 2 whose ready flag
  // reflects free space as of the last clock edge.
  logic [W-1:0] q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, W'(dn.valid), W'(q.size() > 0));
    chk({tag, ".in_ready"},  W'(up.ready), W'(q.size() < 2));
    chk({tag, ".occupancy"}, W'(occupancy), W'(q.size()));
    chk({tag, ".out_data"},  dn.data, (q.size() > 0) ? q[0] : BUB);
  endtask

  task automatic step(input string tag, input bit iv, input logic [W-1:0] d,
                      input bit ordy, input bit fl);
    bit in_fire, out_fire;
    up.valid = iv;
    up.data  = d;
    dn.ready = ordy;
    flush    = fl;
    @(posedge clk);
    in_fire  = iv && (q.size() < 2);
    out_fire = ordy && (q.size() > 0);
    if (fl) begin
      q.delete();
    end else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire)  q.push_back(d);
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    up.valid = 1'b0;
    up.data  = '0;
    dn.ready = 1'b0;
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    step("idle", 1'b0, '0, 1'b1, 1'b0);

    // streaming at full rate
    for (int i = 1; i <= 8; i++) step("stream", 1'b1, W'(i), 1'b1, 1'b0);
    step("stream_tail", 1'b0, '0, 1'b1, 1'b0);
    step("stream_idle", 1'b0, '0, 1'b1, 1'b0);

    // stall fills both entries, then drain in order
    step("stall", 1'b1, W'(8'hA1), 1'b0, 1'b0);
    step("stall", 1'b1, W'(8'hA2), 1'b0, 1'b0);
    chk("stall_full_occ", W'(occupancy), W'(2));
    step("stall", 1'b1, W'(8'hA3), 1'b0, 1'b0);
    chk("stall_hold_a1", dn.data, W'(8'hA1));
    step("release", 1'b1, W'(8'hA3), 1'b1, 1'b0);
    step("release", 1'b1, W'(8'hA3), 1'b1, 1'b0);
    step("release", 1'b0, '0, 1'b1, 1'b0);
    step("release", 1'b0, '0, 1'b1, 1'b0);

    // flush while full with a coincident input
    step("pre_flush", 1'b1, W'(8'h11), 1'b0, 1'b0);
    step("pre_flush", 1'b1, W'(8'h22), 1'b0, 1'b0);
    step("flush_full", 1'b1, W'(8'hFF), 1'b0, 1'b1);
    chk("flush_bubble", dn.data, BUB);
    step("post_flush", 1'b0, '0, 1'b1, 1'b0);

    // flush while M is being consumed downstream
    step("pre_flush2", 1'b1, W'(8'h55), 1'b0, 1'b0);
    chk("flush2_m55", dn.data, W'(8'h55));
    step("flush_fire", 1'b1, W'(8'h66), 1'b1, 1'b1);
    step("post_flush2", 1'b0, '0, 1'b1, 1'b0);

    // asynchronous reset mid-stream
    step("pre_reset", 1'b1, W'(8'h77), 1'b0, 1'b0);
    step("pre_reset", 1'b1, W'(8'h78), 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    check_outputs("mid_reset");
    @(negedge clk);
    check_outputs("held_reset");
    rst = 1'b1;
    step("after_reset", 1'b0, '0, 1'b1, 1'b0);

    // random traffic
    for (int n = 0; n < 10000; n++) begin
      step("rand",
           1'($urandom_range(0, 3) != 0),
           W'({$urandom(), $urandom(), $urandom()}),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 31) == 0));
    end
    for (int n = 0; n < 3; n++) step("drain", 1'b0, '0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
